// File: rtl/custom_cpu_dmem_bridge_pkg.sv
// Shared types for the CPU data-memory bridge: FSM states, UART address, status layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package custom_cpu_dmem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACK    = 3'd2,
    ST_RD_RAM = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  localparam logic [31:0] UART_TX_ADDR_DEF = 32'h6000_0000;

  // Bit positions inside the UART status word returned on a UART read
  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;

  function automatic logic [31:0] uart_status(input logic full, input logic empty);
    logic [31:0] s;
    s                 = '0;
    s[STAT_FULL_BIT]  = full;
    s[STAT_EMPTY_BIT] = empty;
    return s;
  endfunction

endpackage

// File: rtl/custom_cpu_dmem_bridge_if.sv
// CPU data-port bundle: request (held until ack) plus load-data valid/ready return.
// Latency: n/a (wires only).
// Backpressure: CPU stalls on Mem_Req_Ack; bridge holds load data until Read_data_Ready.
interface custom_cpu_dmem_bridge_if;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        Mem_Req_Ack;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;

  modport master (
    output MemWrite, MemRead, Address, Write_data, Write_strb, Read_data_Ready,
    input  Mem_Req_Ack, Read_data, Read_data_Valid
  );

  modport slave (
    input  MemWrite, MemRead, Address, Write_data, Write_strb, Read_data_Ready,
    output Mem_Req_Ack, Read_data, Read_data_Valid
  );
endinterface

// File: rtl/custom_cpu_dmem_bridge_tx_fifo.sv
// Byte FIFO between the bridge and the UART model; head is shown while non-empty.
// Latency: a push becomes visible at the head one cycle later (no bypass when empty).
// Backpressure: push dropped when full unless a pop happens in the same cycle.
module custom_cpu_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign wr_d    = wr_q + {{AW{1'b0}}, do_push};
  assign rd_d    = rd_q + {{AW{1'b0}}, do_pop};
  assign head_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  // Pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_dat_i;
  end
endmodule

// File: rtl/custom_cpu_dmem_bridge.sv
// CPU data-port slave: routes requests to a 1-cycle SRAM or a UART TX FIFO/status register.
// Latency: ack REQ_DELAY+1 cycles after the request is seen; load data valid the cycle after ack.
// Backpressure: UART writes stall in ACK while the FIFO is full; load data held until ready.
module custom_cpu_dmem_bridge
  import custom_cpu_dmem_pkg::*;
#(
  parameter int          MEM_AW       = 12,
  parameter int          REQ_DELAY    = 2,
  parameter logic [31:0] UART_TX_ADDR = UART_TX_ADDR_DEF,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  custom_cpu_dmem_bridge_if.slave cpu,
  output logic                  ram_en,
  output logic [3:0]            ram_wen,
  output logic [MEM_AW-1:0]     ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  output logic [7:0]            uart_tx_data,
  output logic                  uart_tx_valid,
  input  logic                  uart_tx_ready,
  output logic                  fifo_empty,
  output logic                  proto_err
);
  localparam logic [3:0] DLY_LAST = (REQ_DELAY == 0) ? 4'd0 : 4'(REQ_DELAY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:2] addr_q;
  logic [31:0] wdata_q, rdata_q;
  logic [3:0]  strb_q;
  logic        wr_q, proto_err_q;
  logic        req, is_uart;
  logic        fifo_full, fifo_empty_w, fifo_pop, fifo_push, fifo_space;
  logic        ack, rd_vld;
  logic [31:0] rd_dat;

  assign req        = cpu.MemWrite | cpu.MemRead;
  assign is_uart    = (addr_q == UART_TX_ADDR[31:2]);
  assign fifo_pop   = uart_tx_ready & ~fifo_empty_w;
  // A pop in the same cycle frees a slot for a push even when full
  assign fifo_space = ~fifo_full | fifo_pop;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and delay-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      ST_IDLE:   if (req) state_d = (REQ_DELAY == 0) ? ST_ACK : ST_WAIT;
      ST_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == DLY_LAST) state_d = ST_ACK;
      end
      ST_ACK: begin
        if (wr_q) begin
          if (!is_uart || fifo_space) state_d = ST_IDLE;
        end else begin
          state_d = is_uart ? ST_RESP : ST_RD_RAM;
        end
      end
      // Load data is already presented in RD_RAM, so a handshake here completes the read
      ST_RD_RAM: state_d = cpu.Read_data_Ready ? ST_IDLE : ST_RESP;
      ST_RESP:   if (cpu.Read_data_Ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; reset forces them quiet in the same cycle
  always_comb begin
    ack       = 1'b0;
    ram_en    = 1'b0;
    ram_wen   = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    rd_vld    = 1'b0;
    rd_dat    = '0;
    fifo_push = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_ACK: begin
          if (wr_q && is_uart) begin
            ack       = fifo_space;
            fifo_push = fifo_space & strb_q[0];
          end else begin
            ack      = 1'b1;
            ram_en   = ~is_uart;
            ram_addr = is_uart ? '0 : addr_q[MEM_AW+1:2];
            if (wr_q && !is_uart) begin
              ram_wen   = strb_q;
              ram_wdata = wdata_q;
            end
          end
        end
        ST_RD_RAM: begin
          rd_vld = 1'b1;
          rd_dat = ram_rdata;
        end
        ST_RESP: begin
          rd_vld = 1'b1;
          rd_dat = rdata_q;
        end
        default: ;
      endcase
    end
  end

  // Request latch, load-data capture and sticky protocol error
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      wr_q        <= 1'b0;
      rdata_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (state_q == ST_IDLE && req) begin
        addr_q  <= cpu.Address[31:2];
        wdata_q <= cpu.Write_data;
        strb_q  <= cpu.Write_strb;
        wr_q    <= cpu.MemWrite;
        if (cpu.MemWrite && cpu.MemRead) proto_err_q <= 1'b1;
      end
      if (state_q == ST_ACK && !wr_q && is_uart) rdata_q <= uart_status(fifo_full, fifo_empty_w);
      if (state_q == ST_RD_RAM) rdata_q <= ram_rdata;
    end
  end

  custom_cpu_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fifo_push),
    .push_dat_i (wdata_q[7:0]),
    .pop_i      (uart_tx_ready),
    .head_o     (uart_tx_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty_w)
  );

  assign cpu.Mem_Req_Ack     = ack;
  assign cpu.Read_data_Valid = rd_vld;
  assign cpu.Read_data       = rd_dat;
  assign uart_tx_valid       = ~fifo_empty_w;
  assign fifo_empty          = fifo_empty_w;
  assign proto_err           = proto_err_q;
endmodule

// File: tb/tb_custom_cpu_dmem_bridge.sv
// Bench for the CPU data-memory bridge: directed scenarios then random traffic vs a reference model.
// Latency: n/a.
// Backpressure: exercises load-data stalls and a full UART FIFO.
module tb_custom_cpu_dmem_bridge;
  localparam int          REQ_DELAY = 2;
  localparam int          MEM_AW    = 12;
  localparam logic [31:0] UART_A    = 32'h6000_0000;

  logic              clk, rst;
  logic              ram_en;
  logic [3:0]        ram_wen;
  logic [MEM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;
  logic [7:0]        uart_tx_data;
  logic              uart_tx_valid, uart_tx_ready, fifo_empty, proto_err;
  logic              man_rdy, rand_rdy, rnd_bit;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] sram [4096];
  logic [31:0] exp_mem [int];
  logic [7:0]  exp_q [$];

  custom_cpu_dmem_bridge_if cpu_if ();

  custom_cpu_dmem_bridge #(
    .MEM_AW       (MEM_AW),
    .REQ_DELAY    (REQ_DELAY),
    .UART_TX_ADDR (UART_A),
    .FIFO_DEPTH   (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu           (cpu_if),
    .ram_en        (ram_en),
    .ram_wen       (ram_wen),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .fifo_empty    (fifo_empty),
    .proto_err     (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign uart_tx_ready = rand_rdy ? rnd_bit : man_rdy;
  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  // Synchronous SRAM: read data appears the cycle after the enable
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wen == 4'b0) ram_rdata <= sram[ram_addr];
      else for (int b = 0; b < 4; b++) if (ram_wen[b]) sram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // UART sink: every popped byte must be the oldest byte written to the TX address
  always @(negedge clk) begin
    if (!rst && uart_tx_valid && uart_tx_ready) begin
      if (exp_q.size() == 0) chk("uart_extra", 32'(uart_tx_data), 32'hFFFF_FFFF);
      else                   chk("uart_byte", 32'(uart_tx_data), 32'(exp_q.pop_front()));
    end
  end

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 4096);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return exp_mem.exists(widx(a)) ? exp_mem[widx(a)] : 32'h0;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    w = model_read(a);
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    exp_mem[widx(a)] = w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cpu_if.MemWrite = 1'b0;
    cpu_if.MemRead = 1'b0;
    cpu_if.Read_data_Ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // One complete CPU transaction: latency, SRAM side-effects, load-data hold and drop
  task automatic do_req(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input int hold);
    int n;
    bit got, is_u;
    logic [31:0] exp_rd;
    is_u = (addr[31:2] == UART_A[31:2]);
    tick();
    cpu_if.MemWrite = wr; cpu_if.MemRead = rd; cpu_if.Address = addr;
    cpu_if.Write_data = data; cpu_if.Write_strb = strb;
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      if (cpu_if.Mem_Req_Ack) got = 1; else n++;
    end
    chk("ack_lat", n, REQ_DELAY + 1);
    if (!got) begin
      cpu_if.MemWrite = 1'b0; cpu_if.MemRead = 1'b0;
      tick();
      return;
    end
    exp_rd = '0;
    if (wr) begin
      if (is_u) begin
        if (strb[0]) exp_q.push_back(data[7:0]);
      end else begin
        chk("wr_ram_en", ram_en, 1);
        chk("wr_addr", 32'(ram_addr), widx(addr));
        chk("wr_wen", 32'(ram_wen), 32'(strb));
        chk("wr_wdata", ram_wdata, data);
        model_write(addr, data, strb);
      end
    end else if (is_u) begin
      chk("rd_uart_ram_en", ram_en, 0);
      exp_rd = {30'b0, exp_q.size() == 16, exp_q.size() == 0};
    end else begin
      chk("rd_ram_en", ram_en, 1);
      chk("rd_wen", 32'(ram_wen), 0);
      chk("rd_addr", 32'(ram_addr), widx(addr));
      exp_rd = model_read(addr);
    end
    tick();
    cpu_if.MemWrite = 1'b0; cpu_if.MemRead = 1'b0;
    if (wr) begin
      @(negedge clk);
      chk("ack_once", cpu_if.Mem_Req_Ack, 0);
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("rd_vld_hold", cpu_if.Read_data_Valid, 1);
        chk("rd_dat_hold", cpu_if.Read_data, exp_rd);
        tick();
      end
      cpu_if.Read_data_Ready = 1'b1;
      @(negedge clk);
      chk("rd_vld", cpu_if.Read_data_Valid, 1);
      chk("rd_dat", cpu_if.Read_data, exp_rd);
      tick();
      cpu_if.Read_data_Ready = 1'b0;
      @(negedge clk);
      chk("rd_drop", cpu_if.Read_data_Valid, 0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    tick();
    rand_rdy = 1'b0; man_rdy = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    tick();
    man_rdy = 1'b0;
    @(negedge clk);
    chk("drain_left", exp_q.size(), 0);
    chk("drain_empty", fifo_empty, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    logic [31:0] a, d;
    for (int i = 0; i < 4096; i++) sram[i] = 32'h0;
    man_rdy = 1'b0; rand_rdy = 1'b0;
    cpu_if.Address = '0; cpu_if.Write_data = '0; cpu_if.Write_strb = '0;
    do_reset();

    @(negedge clk);
    chk("rst_ack", cpu_if.Mem_Req_Ack, 0);
    chk("rst_vld", cpu_if.Read_data_Valid, 0);
    chk("rst_rdata", cpu_if.Read_data, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_uart_vld", uart_tx_valid, 0);
    chk("rst_fifo_empty", fifo_empty, 1);
    chk("rst_proto_err", proto_err, 0);

    // UART status read with an empty FIFO
    do_req(0, 1, UART_A, 32'h0, 4'h0, 0);

    // SRAM store then load with the load data held for 5 cycles
    do_req(1, 0, 32'h0000_0100, 32'h1234_5678, 4'hF, 0);
    do_req(0, 1, 32'h0000_0100, 32'h0, 4'h0, 5);

    // Single UART byte, then drain it
    do_req(1, 0, UART_A, 32'h0000_0041, 4'h1, 0);
    chk("uart_vld", uart_tx_valid, 1);
    chk("uart_dat", 32'(uart_tx_data), 32'h41);
    chk("uart_not_empty", fifo_empty, 0);
    tick(); man_rdy = 1'b1;
    @(negedge clk);
    tick(); man_rdy = 1'b0;
    @(negedge clk);
    chk("uart_empty_after_pop", fifo_empty, 1);

    // Fill the FIFO, stall the 17th write, release it with a single pop
    for (int i = 0; i < 16; i++) do_req(1, 0, UART_A, 32'h30 + i, 4'h1, 0);
    tick();
    cpu_if.MemWrite = 1'b1; cpu_if.Address = UART_A; cpu_if.Write_data = 32'h99; cpu_if.Write_strb = 4'h1;
    acks = 0;
    repeat (12) begin @(negedge clk); if (cpu_if.Mem_Req_Ack) acks++; end
    chk("stall_no_ack", acks, 0);
    tick(); man_rdy = 1'b1;
    @(negedge clk);
    chk("stall_release_ack", cpu_if.Mem_Req_Ack, 1);
    if (cpu_if.Mem_Req_Ack) exp_q.push_back(8'h99);
    tick(); man_rdy = 1'b0; cpu_if.MemWrite = 1'b0;
    do_req(0, 1, UART_A, 32'h0, 4'h0, 1);
    drain();

    // Read and write together: performed as a write, sticky error flag
    do_req(1, 1, 32'h0000_0300, 32'hCAFE_F00D, 4'hF, 0);
    chk("proto_err_set", proto_err, 1);
    do_req(0, 1, 32'h0000_0300, 32'h0, 4'h0, 0);
    chk("proto_err_sticky", proto_err, 1);

    // Random traffic against the reference model
    tick(); rand_rdy = 1'b1;
    for (int t = 0; t < 60; t++) begin
      a = $urandom();
      a[13:2] = 12'($urandom_range(0, 15));
      if (a[31:2] == UART_A[31:2]) a[31] = ~a[31];
      d = $urandom();
      case ($urandom_range(0, 2))
        0:       do_req(1, 0, a, d, 4'($urandom_range(1, 15)), 0);
        1:       do_req(0, 1, a, 32'h0, 4'h0, $urandom_range(0, 3));
        default: do_req(1, 0, UART_A | 32'($urandom_range(0, 3)), d, 4'($urandom_range(0, 15)), 0);
      endcase
    end
    drain();

    // Reset during the delay window aborts a store
    a = 32'h0000_0200;
    d = model_read(a);
    tick();
    cpu_if.MemWrite = 1'b1; cpu_if.Address = a; cpu_if.Write_data = 32'hDEAD_BEEF; cpu_if.Write_strb = 4'hF;
    @(negedge clk);
    tick(); rst = 1'b1;
    @(negedge clk);
    chk("rst_wait_ack", cpu_if.Mem_Req_Ack, 0);
    chk("rst_wait_ram_en", ram_en, 0);
    tick(); rst = 1'b0; cpu_if.MemWrite = 1'b0; exp_q.delete();
    @(negedge clk);
    chk("post_rst_ack", cpu_if.Mem_Req_Ack, 0);
    chk("post_rst_vld", cpu_if.Read_data_Valid, 0);
    chk("post_rst_proto_err", proto_err, 0);
    chk("post_rst_fifo_empty", fifo_empty, 1);
    repeat (6) begin @(negedge clk); if (cpu_if.Mem_Req_Ack) chk("post_rst_late_ack", 1, 0); end
    do_req(0, 1, a, 32'h0, 4'h0, 0);
    chk("aborted_store_kept", model_read(a), d);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
